// File: rtl/anabellek_denetleyici_pkg.sv
// Shared definitions for the main-memory controller: FSM states, requester IDs, beats per block.
package anabellek_denetleyici_pkg;

    // Number of main-memory words in one cache block
    localparam int unsigned OBEK_KELIME = 4;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        YAZ   = 2'd1,
        OKU   = 2'd2,
        BITTI = 2'd3
    } durum_e;

    typedef enum logic {
        ISTEKCI_BELLEK = 1'b0,
        ISTEKCI_GETIR  = 1'b1
    } istekci_e;

endpackage

// File: rtl/anabellek_hakem.sv
// Round-robin arbiter between the memory stage and the fetch stage.
// On a tie the stage that was not served last wins; after reset the memory stage wins.
module anabellek_hakem
    import anabellek_denetleyici_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     bellek_istek_i,
    input  logic     getir_istek_i,
    input  logic     guncelle_i,
    input  istekci_e sunulan_i,
    output logic     izin_o,
    output istekci_e secilen_o
);

    // 1: fetch stage wins the next tie
    logic oncelik_getir_q;

    // Remember who was served so the other side gets the next tie
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oncelik_getir_q <= 1'b0;
        end else if (guncelle_i) begin
            oncelik_getir_q <= (sunulan_i == ISTEKCI_BELLEK);
        end
    end

    // Grant decision from the current requests and the priority flag
    always_comb begin
        izin_o    = bellek_istek_i | getir_istek_i;
        secilen_o = ISTEKCI_BELLEK;
        if (getir_istek_i && (!bellek_istek_i || oncelik_getir_q)) begin
            secilen_o = ISTEKCI_GETIR;
        end
    end

endmodule

// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: serves 128-bit block reads/writes from the memory and fetch stages
// as four 32-bit word transactions on a valid/accept port, and pulses hazir when done.
module anabellek_denetleyici
    import anabellek_denetleyici_pkg::*;
#(
    parameter int unsigned ADRES_W = 32,
    parameter int unsigned VERI_W  = 32,
    parameter int unsigned OBEK_W  = 128
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               bellek_asamasi_istek_i,
    input  logic [ADRES_W-1:0] bellek_adres_i,
    input  logic               bellek_oku_i,
    input  logic               bellek_yaz_i,
    input  logic [OBEK_W-1:0]  yazilacak_veri_obegi_i,
    output logic               anabellek_musait_o,
    output logic               bellek_asamasina_veri_hazir_o,
    input  logic               getir_istek_i,
    input  logic [ADRES_W-1:0] getir_adres_i,
    output logic               getir_asamasina_veri_hazir_o,
    output logic [OBEK_W-1:0]  okunan_veri_obegi_o,
    output logic               ana_istek_o,
    output logic               ana_yaz_o,
    output logic [ADRES_W-1:0] ana_adres_o,
    output logic [VERI_W-1:0]  ana_veri_o,
    input  logic               ana_kabul_i,
    input  logic               ana_veri_gecerli_i,
    input  logic [VERI_W-1:0]  ana_veri_i
);

    localparam int unsigned SAYAC_W = 3;
    localparam logic [SAYAC_W-1:0] KELIME_SAYISI = SAYAC_W'(OBEK_KELIME);
    localparam logic [SAYAC_W-1:0] SON_KELIME    = SAYAC_W'(OBEK_KELIME - 1);
    // Clears the byte-offset-within-block bits of a request address
    localparam logic [ADRES_W-1:0] HIZA_MASKESI  = ~ADRES_W'(OBEK_W / 8 - 1);

    durum_e               durum_q, durum_d;
    logic [ADRES_W-1:0]   adres_q, adres_d;
    logic [OBEK_W-1:0]    blok_q, blok_d;
    istekci_e             istekci_q, istekci_d;
    logic [SAYAC_W-1:0]   gonder_q, gonder_d;  // accepted word requests
    logic [SAYAC_W-1:0]   al_q, al_d;          // stored read responses
    logic [OBEK_W-1:0]    tampon_q, tampon_d;
    logic [OBEK_W-1:0]    okunan_q, okunan_d;

    logic                 bellek_gecerli;
    logic                 hakem_izin;
    istekci_e             hakem_secim;
    logic                 hakem_guncelle;
    logic                 vurus_istek;
    logic [ADRES_W-1:0]   secilen_adres;

    // A memory-stage request with neither read nor write is not a request at all
    assign bellek_gecerli = bellek_asamasi_istek_i & (bellek_oku_i | bellek_yaz_i);
    assign hakem_guncelle = (durum_q == BITTI);

    anabellek_hakem u_hakem (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .bellek_istek_i (bellek_gecerli),
        .getir_istek_i  (getir_istek_i),
        .guncelle_i     (hakem_guncelle),
        .sunulan_i      (istekci_q),
        .izin_o         (hakem_izin),
        .secilen_o      (hakem_secim)
    );

    // State, latched request and read buffer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q   <= BOSTA;
            adres_q   <= '0;
            blok_q    <= '0;
            istekci_q <= ISTEKCI_BELLEK;
            gonder_q  <= '0;
            al_q      <= '0;
            tampon_q  <= '0;
            okunan_q  <= '0;
        end else begin
            durum_q   <= durum_d;
            adres_q   <= adres_d;
            blok_q    <= blok_d;
            istekci_q <= istekci_d;
            gonder_q  <= gonder_d;
            al_q      <= al_d;
            tampon_q  <= tampon_d;
            okunan_q  <= okunan_d;
        end
    end

    // Next-state: grant, beat issue/accept counting and response reassembly
    always_comb begin
        durum_d       = durum_q;
        adres_d       = adres_q;
        blok_d        = blok_q;
        istekci_d     = istekci_q;
        gonder_d      = gonder_q;
        al_d          = al_q;
        tampon_d      = tampon_q;
        okunan_d      = okunan_q;
        secilen_adres = (hakem_secim == ISTEKCI_GETIR) ? getir_adres_i : bellek_adres_i;

        unique case (durum_q)
            BOSTA: begin
                if (hakem_izin) begin
                    adres_d   = secilen_adres & HIZA_MASKESI;
                    blok_d    = yazilacak_veri_obegi_i;
                    istekci_d = hakem_secim;
                    gonder_d  = '0;
                    al_d      = '0;
                    // Write wins when the memory stage raises both oku and yaz
                    if (hakem_secim == ISTEKCI_BELLEK && bellek_yaz_i) begin
                        durum_d = YAZ;
                    end else begin
                        durum_d = OKU;
                    end
                end
            end
            YAZ: begin
                if (ana_kabul_i) begin
                    gonder_d = gonder_q + 3'd1;
                    if (gonder_q == SON_KELIME) begin
                        durum_d = BITTI;
                    end
                end
            end
            OKU: begin
                if (gonder_q < KELIME_SAYISI && ana_kabul_i) begin
                    gonder_d = gonder_q + 3'd1;
                end
                if (ana_veri_gecerli_i && al_q < KELIME_SAYISI) begin
                    tampon_d[al_q[1:0]*VERI_W +: VERI_W] = ana_veri_i;
                    al_d = al_q + 3'd1;
                    if (al_q == SON_KELIME) begin
                        // Publish the block including the word arriving this cycle
                        okunan_d = tampon_d;
                        durum_d  = BITTI;
                    end
                end
            end
            BITTI: begin
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // Word-port drive and completion pulses, all decoded from registered state
    always_comb begin
        vurus_istek = (durum_q == YAZ) || (durum_q == OKU && gonder_q < KELIME_SAYISI);
        ana_istek_o = vurus_istek;
        ana_yaz_o   = (durum_q == YAZ);
        ana_adres_o = '0;
        ana_veri_o  = '0;
        if (vurus_istek) begin
            ana_adres_o = adres_q + ADRES_W'({gonder_q, 2'b00});
        end
        if (durum_q == YAZ) begin
            ana_veri_o = blok_q[gonder_q[1:0]*VERI_W +: VERI_W];
        end
        anabellek_musait_o            = (durum_q == BOSTA);
        bellek_asamasina_veri_hazir_o = (durum_q == BITTI) && (istekci_q == ISTEKCI_BELLEK);
        getir_asamasina_veri_hazir_o  = (durum_q == BITTI) && (istekci_q == ISTEKCI_GETIR);
        okunan_veri_obegi_o           = okunan_q;
    end

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Directed bench for anabellek_denetleyici with a small in-bench main-memory responder.
module tb_anabellek_denetleyici;

    logic         clk_i;
    logic         rst_i;
    logic         bellek_asamasi_istek_i;
    logic [31:0]  bellek_adres_i;
    logic         bellek_oku_i;
    logic         bellek_yaz_i;
    logic [127:0] yazilacak_veri_obegi_i;
    logic         anabellek_musait_o;
    logic         bellek_asamasina_veri_hazir_o;
    logic         getir_istek_i;
    logic [31:0]  getir_adres_i;
    logic         getir_asamasina_veri_hazir_o;
    logic [127:0] okunan_veri_obegi_o;
    logic         ana_istek_o;
    logic         ana_yaz_o;
    logic [31:0]  ana_adres_o;
    logic [31:0]  ana_veri_o;
    logic         ana_kabul_i;
    logic         ana_veri_gecerli_i;
    logic [31:0]  ana_veri_i;

    anabellek_denetleyici u_dut (
        .clk_i                         (clk_i),
        .rst_i                         (rst_i),
        .bellek_asamasi_istek_i        (bellek_asamasi_istek_i),
        .bellek_adres_i                (bellek_adres_i),
        .bellek_oku_i                  (bellek_oku_i),
        .bellek_yaz_i                  (bellek_yaz_i),
        .yazilacak_veri_obegi_i        (yazilacak_veri_obegi_i),
        .anabellek_musait_o            (anabellek_musait_o),
        .bellek_asamasina_veri_hazir_o (bellek_asamasina_veri_hazir_o),
        .getir_istek_i                 (getir_istek_i),
        .getir_adres_i                 (getir_adres_i),
        .getir_asamasina_veri_hazir_o  (getir_asamasina_veri_hazir_o),
        .okunan_veri_obegi_o           (okunan_veri_obegi_o),
        .ana_istek_o                   (ana_istek_o),
        .ana_yaz_o                     (ana_yaz_o),
        .ana_adres_o                   (ana_adres_o),
        .ana_veri_o                    (ana_veri_o),
        .ana_kabul_i                   (ana_kabul_i),
        .ana_veri_gecerli_i            (ana_veri_gecerli_i),
        .ana_veri_i                    (ana_veri_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int test_sayisi = 0;
    int hata_sayisi = 0;

    // Responder / observation state
    logic [31:0] yanit_q[$];
    logic        desen[$];
    logic [31:0] kabul_adres[$];
    logic [31:0] kabul_veri[$];
    logic [31:0] istek_adres[$];
    int          sunum[$];
    int          musait_dusuk, bellek_hazir_say, getir_hazir_say, verilen_yanit, istek_dongu;
    logic        yanit_bekliyor;

    // Issued address index per cycle for the 1,0,0,1,0,1,1 stall pattern
    int          harita[7] = '{0, 1, 1, 1, 2, 2, 3};

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen,
                           input logic [127:0] beklenen);
        test_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: gozlenen=%0h beklenen=%0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic temizle();
        yanit_q.delete();
        desen.delete();
        kabul_adres.delete();
        kabul_veri.delete();
        istek_adres.delete();
        sunum.delete();
        musait_dusuk     = 0;
        bellek_hazir_say = 0;
        getir_hazir_say  = 0;
        verilen_yanit    = 0;
        istek_dongu      = 0;
        yanit_bekliyor   = 1'b0;
    endtask

    // Called at a negedge: record this cycle's outputs and drive inputs for the next edge
    task automatic cevrim();
        logic kabul;
        if (!anabellek_musait_o) musait_dusuk++;
        if (bellek_asamasina_veri_hazir_o) begin
            bellek_hazir_say++;
            sunum.push_back(0);
        end
        if (getir_asamasina_veri_hazir_o) begin
            getir_hazir_say++;
            sunum.push_back(1);
        end
        kabul = 1'b1;
        if (ana_istek_o) begin
            if (istek_dongu < desen.size()) kabul = desen[istek_dongu];
            istek_dongu++;
            istek_adres.push_back(ana_adres_o);
        end
        ana_kabul_i = kabul;
        if (ana_istek_o && kabul) begin
            kabul_adres.push_back(ana_adres_o);
            kabul_veri.push_back(ana_veri_o);
        end
        // Read data comes back one cycle after its acceptance
        if (yanit_bekliyor) begin
            ana_veri_gecerli_i = 1'b1;
            ana_veri_i = (yanit_q.size() > 0) ? yanit_q.pop_front() : 32'h0;
            verilen_yanit++;
        end else begin
            ana_veri_gecerli_i = 1'b0;
            ana_veri_i = 32'h0;
        end
        yanit_bekliyor = ana_istek_o && !ana_yaz_o && kabul;
    endtask

    // Run cycles until a hazir pulse is seen; returns at that negedge
    task automatic calistir(input int sinir, output int gecikme);
        bit bitti;
        bitti = 0;
        gecikme = 0;
        while (!bitti && gecikme < sinir) begin
            @(negedge clk_i);
            gecikme++;
            cevrim();
            if (bellek_asamasina_veri_hazir_o || getir_asamasina_veri_hazir_o) bitti = 1;
        end
        kontrol("zaman_asimi", 128'(bitti), 128'd1);
    endtask

    task automatic reset_kontrol(input string on);
        kontrol({on, "_istek"}, 128'(ana_istek_o), 128'd0);
        kontrol({on, "_yaz"}, 128'(ana_yaz_o), 128'd0);
        kontrol({on, "_adres"}, 128'(ana_adres_o), 128'd0);
        kontrol({on, "_veri"}, 128'(ana_veri_o), 128'd0);
        kontrol({on, "_bhazir"}, 128'(bellek_asamasina_veri_hazir_o), 128'd0);
        kontrol({on, "_ghazir"}, 128'(getir_asamasina_veri_hazir_o), 128'd0);
        kontrol({on, "_okunan"}, okunan_veri_obegi_o, 128'd0);
        kontrol({on, "_musait"}, 128'(anabellek_musait_o), 128'd1);
    endtask

    initial begin
        int gecikme;
        int n;
        logic [127:0] blok;

        rst_i = 1'b1;
        bellek_asamasi_istek_i = 1'b0;
        bellek_adres_i = '0;
        bellek_oku_i = 1'b0;
        bellek_yaz_i = 1'b0;
        yazilacak_veri_obegi_i = '0;
        getir_istek_i = 1'b0;
        getir_adres_i = '0;
        ana_kabul_i = 1'b0;
        ana_veri_gecerli_i = 1'b0;
        ana_veri_i = '0;
        temizle();

        repeat (2) @(negedge clk_i);
        reset_kontrol("reset");
        rst_i = 1'b0;

        // Memory-stage write, zero-wait memory
        @(negedge clk_i);
        temizle();
        blok = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        bellek_asamasi_istek_i = 1'b1;
        bellek_yaz_i = 1'b1;
        bellek_adres_i = 32'h0000_1234;
        yazilacak_veri_obegi_i = blok;
        calistir(30, gecikme);
        bellek_asamasi_istek_i = 1'b0;
        bellek_yaz_i = 1'b0;
        kontrol("yaz_gecikme", 128'(gecikme), 128'd5);
        kontrol("yaz_vurus_sayisi", 128'(kabul_adres.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            kontrol($sformatf("yaz_adres%0d", i),
                    128'((kabul_adres.size() > i) ? kabul_adres[i] : 32'hx),
                    128'(32'h1230 + 4 * i));
            kontrol($sformatf("yaz_veri%0d", i),
                    128'((kabul_veri.size() > i) ? kabul_veri[i] : 32'hx), 128'(blok[32*i +: 32]));
        end
        kontrol("yaz_bhazir_sayisi", 128'(bellek_hazir_say), 128'd1);
        kontrol("yaz_ghazir_sayisi", 128'(getir_hazir_say), 128'd0);
        kontrol("yaz_musait_dusuk", 128'(musait_dusuk), 128'd5);

        // Fetch read, responses one cycle after each accept
        @(negedge clk_i);
        cevrim();
        temizle();
        yanit_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        getir_istek_i = 1'b1;
        getir_adres_i = 32'h0000_0040;
        calistir(30, gecikme);
        getir_istek_i = 1'b0;
        kontrol("oku_gecikme", 128'(gecikme), 128'd6);
        kontrol("oku_blok", okunan_veri_obegi_o,
                128'h00000044_00000033_00000022_00000011);
        kontrol("oku_ghazir_sayisi", 128'(getir_hazir_say), 128'd1);
        kontrol("oku_bhazir_sayisi", 128'(bellek_hazir_say), 128'd0);
        for (int i = 0; i < 4; i++) begin
            kontrol($sformatf("oku_adres%0d", i),
                    128'((kabul_adres.size() > i) ? kabul_adres[i] : 32'hx),
                    128'(32'h40 + 4 * i));
        end

        // Write with back-pressure on the accept line
        @(negedge clk_i);
        cevrim();
        temizle();
        desen = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        blok = 128'h44444444_33333333_22222222_11111111;
        bellek_asamasi_istek_i = 1'b1;
        bellek_yaz_i = 1'b1;
        bellek_adres_i = 32'h0000_2008;
        yazilacak_veri_obegi_i = blok;
        calistir(30, gecikme);
        bellek_asamasi_istek_i = 1'b0;
        bellek_yaz_i = 1'b0;
        kontrol("bp_istek_dongu", 128'(istek_adres.size()), 128'd7);
        for (int i = 0; i < 7; i++) begin
            kontrol($sformatf("bp_tutulan_adres%0d", i),
                    128'((istek_adres.size() > i) ? istek_adres[i] : 32'hx),
                    128'(32'h2000 + 4 * harita[i]));
        end
        kontrol("bp_vurus_sayisi", 128'(kabul_veri.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            kontrol($sformatf("bp_veri%0d", i),
                    128'((kabul_veri.size() > i) ? kabul_veri[i] : 32'hx), 128'(blok[32*i +: 32]));
        end

        // Simultaneous requests after reset: bellek, getir, bellek
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        temizle();
        yanit_q = '{32'h101, 32'h102, 32'h103, 32'h104};
        bellek_asamasi_istek_i = 1'b1;
        bellek_yaz_i = 1'b1;
        bellek_adres_i = 32'h0000_3000;
        yazilacak_veri_obegi_i = 128'h1;
        getir_istek_i = 1'b1;
        getir_adres_i = 32'h0000_5000;
        for (int i = 0; i < 3; i++) calistir(40, gecikme);
        bellek_asamasi_istek_i = 1'b0;
        bellek_yaz_i = 1'b0;
        getir_istek_i = 1'b0;
        kontrol("rr_sunum_sayisi", 128'(sunum.size()), 128'd3);
        for (int i = 0; i < 3; i++) begin
            kontrol($sformatf("rr_sira%0d", i), 128'((sunum.size() > i) ? sunum[i] : -1),
                    128'((i == 1) ? 1 : 0));
        end
        kontrol("rr_oku_blok", okunan_veri_obegi_o,
                128'h00000104_00000103_00000102_00000101);

        // Reset in the middle of a read, after two responses
        @(negedge clk_i);
        cevrim();
        temizle();
        yanit_q = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        getir_istek_i = 1'b1;
        getir_adres_i = 32'h0000_0080;
        n = 0;
        while (verilen_yanit < 2 && n < 20) begin
            @(negedge clk_i);
            n++;
            cevrim();
        end
        kontrol("rst_yanit_bekleme", 128'(verilen_yanit), 128'd2);
        @(negedge clk_i);
        rst_i = 1'b1;
        getir_istek_i = 1'b0;
        ana_kabul_i = 1'b0;
        ana_veri_gecerli_i = 1'b0;
        #1;
        reset_kontrol("ara_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        temizle();
        repeat (3) begin
            ana_veri_gecerli_i = 1'b1;
            ana_veri_i = 32'hDEAD_BEEF;
            @(negedge clk_i);
            if (!anabellek_musait_o || ana_istek_o) musait_dusuk++;
            if (bellek_asamasina_veri_hazir_o || getir_asamasina_veri_hazir_o) getir_hazir_say++;
        end
        ana_veri_gecerli_i = 1'b0;
        kontrol("bayat_yanit_hazir", 128'(getir_hazir_say), 128'd0);
        kontrol("bayat_yanit_mesgul", 128'(musait_dusuk), 128'd0);
        kontrol("bayat_yanit_okunan", okunan_veri_obegi_o, 128'd0);

        // Memory-stage request with neither oku nor yaz is ignored
        temizle();
        bellek_asamasi_istek_i = 1'b1;
        bellek_oku_i = 1'b0;
        bellek_yaz_i = 1'b0;
        bellek_adres_i = 32'h0000_9000;
        repeat (5) begin
            @(negedge clk_i);
            cevrim();
        end
        bellek_asamasi_istek_i = 1'b0;
        kontrol("bos_istek_vurus", 128'(istek_adres.size()), 128'd0);
        kontrol("bos_istek_musait", 128'(musait_dusuk), 128'd0);
        kontrol("bos_istek_hazir", 128'(bellek_hazir_say + getir_hazir_say), 128'd0);

        $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
        $finish;
    end

endmodule

// File: doc/anabellek_denetleyici.md
Name: anabellek_denetleyici

Overview:
- Main-memory controller that sits directly downstream of the memory stage's data-cache controller and the fetch stage's instruction-cache controller.
- Accepts 128-bit block read and write requests from both stages and arbitrates between them round-robin.
- Converts each block into four 32-bit word transactions on a valid/accept main-memory port, reassembles read responses into a 128-bit block, and returns a one-cycle ready pulse to the stage that was served.

Parameters:
- ADRES_W, 32, address width.
- VERI_W, 32, main-memory word width.
- OBEK_W, 128, cache block width; beats per block = OBEK_W/VERI_W = 4.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- bellek_asamasi_istek_i  input  1  memory-stage request
- bellek_adres_i  input  ADRES_W  memory-stage block address
- bellek_oku_i  input  1  memory-stage block read
- bellek_yaz_i  input  1  memory-stage block write
- yazilacak_veri_obegi_i  input  OBEK_W  block to write
- anabellek_musait_o  output  1  controller idle, memory stage may request
- bellek_asamasina_veri_hazir_o  output  1  memory-stage transaction done pulse
- getir_istek_i  input  1  fetch-stage block read request
- getir_adres_i  input  ADRES_W  fetch-stage block address
- getir_asamasina_veri_hazir_o  output  1  fetch-stage read done pulse
- okunan_veri_obegi_o  output  OBEK_W  assembled read block, shared by both stages
- ana_istek_o  output  1  word request valid
- ana_yaz_o  output  1  1 = write word, 0 = read word
- ana_adres_o  output  ADRES_W  word address
- ana_veri_o  output  VERI_W  write word
- ana_kabul_i  input  1  main memory accepts current word request
- ana_veri_gecerli_i  input  1  read response word valid
- ana_veri_i  input  VERI_W  read response word

Behaviour:
- Reset (async, rst_i=1), all outputs at these values:
  - ana_istek_o=0, ana_yaz_o=0, ana_adres_o=0, ana_veri_o=0.
  - Both hazir pulses 0, okunan_veri_obegi_o=0.
  - anabellek_musait_o=1 (combinational from state BOSTA).
  - Counters 0; round-robin flag favours memory stage.
- States: BOSTA, YAZ, OKU, BITTI.
- BOSTA:
  - Samples requests; the requester holds istek, address and data stable until its hazir pulse.
  - Only memory stage requesting -> grant it. Only fetch requesting -> grant fetch.
  - Both requesting -> grant the stage not served last.
  - At grant, latch base address with bits [3:0] forced to 0, latch the write block, record the requester.
  - Memory-stage grant: bellek_yaz_i=1 -> YAZ; else bellek_oku_i=1 -> OKU.
  - Memory-stage istek with neither oku nor yaz -> ignored, remain BOSTA.
  - Memory-stage oku and yaz both 1 -> write wins (YAZ).
  - Fetch grant is always a read -> OKU.
- YAZ:
  - ana_istek_o=1, ana_yaz_o=1.
  - ana_adres_o = base + 4*k; ana_veri_o = block word k, where word k = bits [32k+31:32k] (k = beat counter).
  - k advances only on a cycle with ana_kabul_i=1.
  - Acceptance of beat 3 -> BITTI. Request deasserts the cycle after the final acceptance.
- OKU:
  - Read requests issued as in YAZ, with ana_yaz_o=0. Issue counter advances on ana_kabul_i and issuing stops after 4 accepted.
  - Receive counter r is independent: each ana_veri_gecerli_i=1 stores ana_veri_i into word r of the buffer. Responses return in order.
  - A response may arrive in the same cycle as its own acceptance or later; overlap of issue and receive is legal.
  - 4th response stored -> BITTI.
- BITTI (exactly one cycle):
  - Pulse hazir for the recorded requester, including memory-stage writes.
  - okunan_veri_obegi_o updated with the buffer on entry to BITTI. Holds its value until the next read completes.
  - Update round-robin flag; next state BOSTA. New grant possible the following cycle.
- anabellek_musait_o=1 only in BOSTA.
- ana_veri_gecerli_i outside OKU, or after 4 responses, is ignored.
- Latency, zero-wait memory (kabul=1 always):
  - Write: grant cycle + 4 beats + BITTI -> hazir 6 cycles after istek is sampled.
  - Read with single-cycle response: hazir 7 cycles after istek is sampled.
- Reset mid-operation: immediate return to BOSTA, counters and buffer cleared, no hazir pulse. Stale responses are ignored.

Decomposition:
- Shared package holds:
  - State encoding constants BOSTA/YAZ/OKU/BITTI (2 bits).
  - Requester ID constants ISTEKCI_BELLEK=0, ISTEKCI_GETIR=1.
  - Constant OBEK_KELIME=4.
- One natural sub-module, anabellek_hakem: round-robin two-requester arbiter holding the last-served flag.

Test Plan:
- Memory-stage write: adres 0x0000_1234, block 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, kabul=1 -> beats (0x1230,AAAAAAAA), (0x1234,BBBBBBBB), (0x1238,CCCCCCCC), (0x123C,DDDDDDDD); one bellek hazir pulse; musait low for 5 cycles.
- Fetch read: adres 0x0000_0040, responses 0x11, 0x22, 0x33, 0x44 one cycle after each accept -> okunan_veri_obegi_o = 0x00000044_00000033_00000022_00000011; only getir hazir pulses.
- Back-pressure: kabul toggles 1,0,0,1,0,1,1 during a write -> address and data held during stall cycles; exactly 4 accepted beats in order.
- Simultaneous requests, both held across three grants after reset -> order bellek, getir, bellek.
- Reset asserted after 2 read responses -> all outputs at reset values next edge; later ana_veri_gecerli_i ignored; no hazir pulse.
- Memory-stage istek with oku=yaz=0 -> no ana_istek_o, musait stays 1.
